// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: qualifies a synchronized lock indication, then releases the
// downstream reset domains in order, with a fixed gap between releases.
//
// state   | meaning
// --------+------------------------------------------------------------
// HOLD    | all domains in reset, counting continuous qualified lock
// RELEASE | releasing domains one at a time, STAGE_GAP cycles apart
// RUN     | all domains out of reset, ready asserted
// SW_HOLD | software-requested reset, all domains held SW_RST_CYCLES
module rst_seq_ctrl #(
   parameter int NUM_STAGES    = 3,
   parameter int HOLD_CYCLES   = 64,
   parameter int STAGE_GAP     = 16,
   parameter int SYNC_STAGES   = 2,
   parameter int SW_RST_CYCLES = 8,
   parameter int CNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lock_in,
   input  logic                  sw_rst_req,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic [NUM_STAGES-1:0] rstn_out,
   output logic                  ready,
   output logic                  busy,
   output logic                  lock_lost
);

   localparam int IDX_W = $clog2(NUM_STAGES + 1);

   localparam logic [CNT_W-1:0]      HOLD_M1   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]      GAP_M1    = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0]      SW_M1     = CNT_W'(SW_RST_CYCLES - 1);
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_STAGES - 1);
   localparam logic [NUM_STAGES-1:0] ALL_ONES  = '1;
   localparam logic [NUM_STAGES-1:0] FIRST_REL = ALL_ONES << 1;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2,
      SW_HOLD = 2'd3
   } state_t;

   state_t                  state, state_d;
   logic [CNT_W-1:0]        cnt, cnt_d;
   logic [IDX_W-1:0]        idx, idx_d;
   logic [NUM_STAGES-1:0]   rst_q, rst_d;
   logic                    lost_q, lost_d;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    lock_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
      end
   end

   assign lock_sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= HOLD;
         cnt    <= '0;
         idx    <= '0;
         rst_q  <= ALL_ONES;
         lost_q <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         idx    <= idx_d;
         rst_q  <= rst_d;
         lost_q <= lost_d;
      end
   end

   // Releases shift a zero in from bit 0, so ordering holds by construction.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      rst_d   = rst_q;
      lost_d  = lost_q;
      case (state)
         HOLD: begin
            if (!lock_sync) begin
               cnt_d = '0;
            end else if (cnt == HOLD_M1) begin
               state_d = RELEASE;
               cnt_d   = '0;
               idx_d   = '0;
               rst_d   = FIRST_REL;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         RELEASE: begin
            if (!lock_sync) begin
               state_d = HOLD;
               cnt_d   = '0;
               idx_d   = '0;
               rst_d   = ALL_ONES;
               lost_d  = 1'b1;
            end else if (idx == LAST_IDX) begin
               state_d = RUN;
               cnt_d   = '0;
            end else if (cnt == GAP_M1) begin
               rst_d = rst_q << 1;
               idx_d = idx + IDX_W'(1);
               cnt_d = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (!lock_sync) begin
               state_d = HOLD;
               cnt_d   = '0;
               idx_d   = '0;
               rst_d   = ALL_ONES;
               lost_d  = 1'b1;
            end else if (sw_rst_req) begin
               state_d = SW_HOLD;
               cnt_d   = '0;
               rst_d   = ALL_ONES;
            end
         end
         SW_HOLD: begin
            if (!lock_sync) begin
               state_d = HOLD;
               cnt_d   = '0;
               idx_d   = '0;
               rst_d   = ALL_ONES;
               lost_d  = 1'b1;
            end else if (cnt == SW_M1) begin
               state_d = RELEASE;
               cnt_d   = '0;
               idx_d   = '0;
               rst_d   = FIRST_REL;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = ALL_ONES;
         end
      endcase
   end

   assign rst_out   = rst_q;
   assign rstn_out  = ~rst_q;
   assign ready     = (state == RUN);
   assign busy      = (state != RUN);
   assign lock_lost = lost_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with default parameters; expected release
// edges are hand-derived from the two-flop lock synchronizer latency.
module tb_rst_seq_ctrl;

   localparam int N = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         lock_in = 1'b0;
   logic         sw_rst_req = 1'b0;
   logic [N-1:0] rst_out;
   logic [N-1:0] rstn_out;
   logic         ready;
   logic         busy;
   logic         lock_lost;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rst_seq_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .lock_in    (lock_in),
      .sw_rst_req (sw_rst_req),
      .rst_out    (rst_out),
      .rstn_out   (rstn_out),
      .ready      (ready),
      .busy       (busy),
      .lock_lost  (lock_lost)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_rst(input string tag, input logic [N-1:0] exp);
      logic [N-1:0] expn;
      expn = ~exp;
      check({tag, ".rst_out"}, 32'(rst_out), 32'(exp));
      check({tag, ".rstn_out"}, 32'(rstn_out), 32'(expn));
   endtask

   task automatic check_flags(input string tag, input logic rdy, input logic lost);
      check({tag, ".ready"}, 32'(ready), 32'(rdy));
      check({tag, ".busy"}, 32'(busy), 32'(!rdy));
      check({tag, ".lock_lost"}, 32'(lock_lost), 32'(lost));
   endtask

   // Called just after edge E0 (last edge with rst high); lock_in already 1.
   task automatic run_seq(input string tag, input logic lost);
      rst = 1'b0;
      step(65); check_rst({tag, "_e65"}, 3'b111);
      step(1);  check_rst({tag, "_e66"}, 3'b110); check_flags({tag, "_e66"}, 1'b0, lost);
      step(15); check_rst({tag, "_e81"}, 3'b110);
      step(1);  check_rst({tag, "_e82"}, 3'b100);
      step(15); check_rst({tag, "_e97"}, 3'b100);
      step(1);  check_rst({tag, "_e98"}, 3'b000); check_flags({tag, "_e98"}, 1'b0, lost);
      step(1);  check_flags({tag, "_e99"}, 1'b1, lost);
   endtask

   initial begin
      lock_in = 1'b1;
      step(3);
      check_rst("reset", 3'b111);
      check_flags("reset", 1'b0, 1'b0);

      // power-up sequence
      run_seq("t1", 1'b0);

      // software reset from RUN, plus an ignored request during RELEASE
      step(5);
      sw_rst_req = 1'b1; step(1); sw_rst_req = 1'b0;
      check_rst("t3_s0", 3'b111); check_flags("t3_s0", 1'b0, 1'b0);
      step(7);  check_rst("t3_s7", 3'b111);
      step(1);  check_rst("t3_s8", 3'b110);
      step(3);
      sw_rst_req = 1'b1; step(1); sw_rst_req = 1'b0;
      check_rst("t5_s12", 3'b110);
      step(11); check_rst("t3_s23", 3'b110);
      step(1);  check_rst("t3_s24", 3'b100);
      step(15); check_rst("t3_s39", 3'b100);
      step(1);  check_rst("t3_s40", 3'b000); check_flags("t3_s40", 1'b0, 1'b0);
      step(1);  check_flags("t3_s41", 1'b1, 1'b0);

      // one-cycle lock drop in RUN, with sw request on the edge lock_sync falls
      step(5);
      lock_in = 1'b0; step(1); lock_in = 1'b1;
      step(1);  check_rst("t4_l2", 3'b000); check_flags("t4_l2", 1'b1, 1'b0);
      sw_rst_req = 1'b1; step(1); sw_rst_req = 1'b0;
      check_rst("t4_l3", 3'b111); check_flags("t4_l3", 1'b0, 1'b1);
      step(8);  check_rst("t5_l11", 3'b111);
      step(55); check_rst("t4_l66", 3'b111);
      step(1);  check_rst("t4_l67", 3'b110);
      step(16); check_rst("t4_l83", 3'b100);
      step(16); check_rst("t4_l99", 3'b000);
      step(1);  check_flags("t4_l100", 1'b1, 1'b1);

      // asynchronous rst in the middle of RELEASE
      step(5);
      sw_rst_req = 1'b1; step(1); sw_rst_req = 1'b0;
      step(8);  check_rst("t6_s8", 3'b110);
      step(2);
      #2; rst = 1'b1;
      #1; check_rst("t6_async", 3'b111); check_flags("t6_async", 1'b0, 1'b0);
      step(2);
      run_seq("t6", 1'b0);

      // lock glitch 40 cycles into HOLD restarts qualification
      step(3);
      rst = 1'b1; step(2); rst = 1'b0;
      step(40);
      lock_in = 1'b0; step(3); lock_in = 1'b1;
      step(23); check_rst("t2_e66", 3'b111);
      step(42); check_rst("t2_e108", 3'b111);
      step(1);  check_rst("t2_e109", 3'b110); check_flags("t2_e109", 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencer for the comm_uart subsystem. It qualifies an external clock-lock indication and holds all downstream reset domains for a fixed interval. It then releases those domains one at a time, in order, with a programmable gap between releases. It also handles software-requested resets and loss of lock at runtime, and gives each domain both polarities of its reset.

Parameters:
NUM_STAGES, 3, number of sequenced reset domains (1..8)
HOLD_CYCLES, 64, cycles lock must be continuously qualified before the first release
STAGE_GAP, 16, cycles between successive stage releases (>=1)
SYNC_STAGES, 2, synchronizer depth for lock_in (>=2)
SW_RST_CYCLES, 8, cycles all resets are held after a software reset request (>=1)
CNT_W, 16, width of the internal delay counter; must hold max(HOLD_CYCLES, STAGE_GAP, SW_RST_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
lock_in  in  1  clock-lock indication, asynchronous to clk
sw_rst_req  in  1  software reset request, single-cycle pulse, synchronous to clk
rst_out  out  NUM_STAGES  active-high per-domain resets; bit 0 is released first
rstn_out  out  NUM_STAGES  active-low copy; always equal to ~rst_out
ready  out  1  high only in RUN
busy  out  1  high in any state other than RUN
lock_lost  out  1  sticky flag, set on lock loss in RELEASE, RUN or SW_HOLD; cleared only by rst

Behaviour:
- Reset values while rst=1:
  - rst_out all 1; rstn_out all 0; ready 0; busy 1; lock_lost 0.
  - State HOLD; counter 0; release index 0; synchronizer flops 0.
- Assertion and release of rst:
  - rst asserts all outputs asynchronously.
  - Every release of rst_out bits is synchronous to the rising edge of clk.
- lock_sync: lock_in passed through SYNC_STAGES flops. The FSM sees lock only through lock_sync.
- HOLD state:
  - Counter increments on each edge where lock_sync=1.
  - Counter clears to 0 on any edge where lock_sync=0.
  - When the counter reaches HOLD_CYCLES-1 with lock_sync=1, go to RELEASE. On that same edge clear rst_out[0] and clear the counter.
- RELEASE state:
  - Counter counts cycles.
  - Each time it reaches STAGE_GAP-1, clear the next rst_out bit (index+1) and clear the counter.
  - After the last bit (NUM_STAGES-1) is cleared, go to RUN on the next edge.
  - With NUM_STAGES=1, go to RUN on the edge after rst_out[0] clears.
- RUN state: ready=1, busy=0, rst_out all 0.
- Lock loss: lock_sync=0 sampled in RELEASE, RUN or SW_HOLD causes, on that edge:
  - all rst_out set to 1;
  - state HOLD, counter 0, index 0;
  - lock_lost set.
- Software reset:
  - sw_rst_req=1 sampled in RUN: on that edge, all rst_out set to 1 and state SW_HOLD with counter 0.
  - After SW_RST_CYCLES edges, go to RELEASE. rst_out[0] clears on that transition edge, then stages follow at STAGE_GAP intervals. HOLD is skipped.
- sw_rst_req is ignored outside RUN (no queuing).
- Priority on the same edge: rst > lock loss > sw_rst_req.
- Releases are strictly in order: a higher stage is never released while a lower stage is still in reset.
- Counter never wraps: it is cleared on every state transition and every stage release.

Test Plan:
1. lock_in=1 constant, rst deasserted at edge E0, defaults:
   - rst_out[0] clears at E0+66, rst_out[1] at E0+82, rst_out[2] at E0+98;
   - ready rises at E0+99;
   - rstn_out is the complement throughout.
2. lock_in glitches low for 3 cycles 40 cycles into HOLD -> hold count restarts; first release occurs 64+SYNC_STAGES cycles after lock_in returns high; lock_lost stays 0.
3. In RUN, sw_rst_req pulse at edge S:
   - rst_out=3'b111 from S;
   - rst_out[0] clears at S+8, rst_out[1] at S+24, rst_out[2] at S+40;
   - ready rises at S+41; lock_lost stays 0.
4. In RUN, lock_in dropped for 1 cycle -> all rst_out=1 two edges later; ready=0; lock_lost=1; full HOLD and release sequence repeats once lock has been high for 64 cycles.
5. sw_rst_req pulsed while in RELEASE, and again on the same edge that lock_sync falls in RUN -> first request ignored, sequence unchanged; second case follows the lock-loss path (HOLD, lock_lost=1).
6. rst asserted mid-RELEASE (after rst_out[0] cleared) -> rst_out returns to all 1 immediately without a clk edge; lock_lost cleared; full sequence restarts after rst falls.
